// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/compare/shift ops, shift-add MUL and restoring DIV/REM.
// Latency: ops 0-10 and divide fast paths 1 cycle after acceptance; MUL/DIV take WIDTH+1 cycles.
// Backpressure: in_ready low while busy or while an untaken result blocks; a finished result parks in HOLD.

module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int               SHW     = $clog2(WIDTH);
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       OP_MUL  = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] wa, wb, acc, hold_q;
  logic             pend;

  logic             accept, start_div;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mul_sum, q_fix, r_fix, iter_res, done_val;

  // Divide cases resolved without iterating: divisor zero, or signed most-negative / -1.
  function automatic logic div_fast(input logic [3:0] f_op, input logic [WIDTH-1:0] fa,
                                    input logic [WIDTH-1:0] fb);
    return (f_op >= 4'd12) &&
           ((fb == '0) || (f_op[1] && (fa == MIN_NEG) && (fb == '1)));
  endfunction

  // Magnitude of an operand for the signed divide ops (op bit 1 marks DIV/REM).
  function automatic logic [WIDTH-1:0] mag(input logic sgn_op, input logic [WIDTH-1:0] x);
    return (sgn_op && x[WIDTH-1]) ? -x : x;
  endfunction

  // Single-cycle result for ops 0-10 and the divide fast paths.
  function automatic logic [WIDTH-1:0] quick(input logic [3:0] f_op, input logic [WIDTH-1:0] fa,
                                             input logic [WIDTH-1:0] fb);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    r  = '0;
    sh = fb[SHW-1:0];
    case (f_op)
      4'd0:          r = fa + fb;
      4'd1:          r = fa - fb;
      4'd2:          r = fa & fb;
      4'd3:          r = fa | fb;
      4'd4:          r = fa ^ fb;
      4'd5:          r = $unsigned($signed(fa) >>> sh);
      4'd6:          r = fa >> sh;
      4'd7:          r = fa << sh;
      4'd8:          r = {{(WIDTH-1){1'b0}}, ($signed(fa) < $signed(fb))};
      4'd9:          r = {{(WIDTH-1){1'b0}}, (fa == fb)};
      4'd10:         r = {{(WIDTH-1){1'b0}}, (fa < fb)};
      4'd12, 4'd14:  r = (fb == '0) ? '1 : fa;
      4'd13, 4'd15:  r = (fb == '0) ? fa : '0;
      default:       r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == MUL) || (state == DIV);
  assign start_div = (op >= 4'd12) && !div_fast(op, operand_a, operand_b);

  // Per-iteration datapath and completion value (sign fix-up happens here, on completion).
  always_comb begin
    trial    = {acc, wa[WIDTH-1]} - {1'b0, wb};
    mul_sum  = acc + (wb[0] ? wa : '0);
    q_fix    = (op_q[1] && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -wa : wa;
    r_fix    = (op_q[1] && a_q[WIDTH-1]) ? -acc : acc;
    iter_res = (op_q == OP_MUL) ? acc : (op_q[0] ? r_fix : q_fix);
    done_val = ((op_q == OP_MUL) || ((op_q >= 4'd12) && !div_fast(op_q, a_q, b_q)))
               ? iter_res : quick(op_q, a_q, b_q);
  end

  // Control FSM, operand capture, iteration registers and the registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wa        <= '0;
      wb        <= '0;
      acc       <= '0;
      hold_q    <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A completed result lands one cycle after acceptance (or after the last iteration).
          if (pend) begin
            pend <= 1'b0;
            if (out_valid && !out_ready) begin
              hold_q <= done_val;
              state  <= HOLD;
            end else begin
              out_data  <= done_val;
              out_valid <= 1'b1;
            end
          end
          if (accept) begin
            op_q <= op;
            a_q  <= operand_a;
            b_q  <= operand_b;
            cnt  <= '0;
            acc  <= '0;
            if (op == OP_MUL) begin
              state <= MUL;
              wa    <= operand_a;
              wb    <= operand_b;
            end else if (start_div) begin
              state <= DIV;
              wa    <= mag(op[1], operand_a);
              wb    <= mag(op[1], operand_b);
            end else begin
              pend <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_sum;
          wa  <= wa << 1;
          wb  <= wb >> 1;
          if (cnt == LAST) begin
            state <= IDLE;
            pend  <= 1'b1;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        DIV: begin
          if (!trial[WIDTH]) begin
            acc <= trial[WIDTH-1:0];
            wa  <= {wa[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[WIDTH-2:0], wa[WIDTH-1]};
            wa  <= {wa[WIDTH-2:0], 1'b0};
          end
          if (cnt == LAST) begin
            state <= IDLE;
            pend  <= 1'b1;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_data  <= hold_q;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (WIDTH=32): directed latency/boundary cases plus randomized traffic.
// Latency: reference results are released in acceptance order and matched on each handshake.
// Backpressure: out_ready is randomized; held results are checked for stability.

module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [31:0] operand_a, operand_b, out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the operation definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned p;
    int              sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    p  = 64'(a) * 64'(b);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return 32'(sa >>> sh);
      4'd6:    return a >> sh;
      4'd7:    return a << sh;
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a == b) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      4'd11:   return p[31:0];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 0) ? a : a % b;
      4'd14:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      default: return (b == 0) ? a : 32'(sa % sb);
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op at a negedge, then measure edges from acceptance to out_valid.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        output int busy_n, output int rdy_n);
    int k;
    busy_n    = 0;
    rdy_n     = 0;
    op        = o;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid  = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
        op        = ~o;
      end
      if (out_valid) break;
      if (busy) busy_n++;
      if (busy && in_ready) rdy_n++;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check({tag, "_dat"}, 64'(out_data), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bn, rn;
    bit          ok;
    bit          prev_hold;
    logic [31:0] prev_dat;
    logic [63:0] exp_v;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; operand_a = '0; operand_b = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_vld",  64'(out_valid), 64'd0);
    check("rst_dat",  64'(out_data),  64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    check("rst_rdy",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("rst_first_rdy", 64'(in_ready), 64'd1);

    // Single-cycle ops and boundaries
    run_op("add_ovf", 4'd0,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1, bn, rn);
    run_op("slt",     4'd8,  32'h8000_0000, 32'h1,  32'h1,         1, bn, rn);
    run_op("sltu",    4'd10, 32'h8000_0000, 32'h1,  32'h0,         1, bn, rn);
    run_op("sra",     4'd5,  32'h8000_0000, 32'h24, 32'hF800_0000, 1, bn, rn);
    run_op("sll",     4'd7,  32'h1,         32'd31, 32'h8000_0000, 1, bn, rn);
    run_op("sub",     4'd1,  32'h0,         32'h1,  32'hFFFF_FFFF, 1, bn, rn);
    run_op("eq",      4'd9,  32'h1234,      32'h1234, 32'h1,       1, bn, rn);

    // Iterative MUL
    run_op("mul", 4'd11, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 33, bn, rn);
    check("mul_busy",   64'(bn), 64'd32);
    check("mul_rdy_lo", 64'(rn), 64'd0);

    // Division: iterative and fast paths
    run_op("div",     4'd14, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, bn, rn);
    run_op("rem",     4'd15, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, bn, rn);
    run_op("divu0",   4'd12, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, bn, rn);
    run_op("remu0",   4'd13, 32'h9, 32'h0, 32'h9,         1, bn, rn);
    run_op("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, bn, rn);
    run_op("rem_ovf", 4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, bn, rn);
    @(negedge clk);

    // HOLD: older ADD result blocks, DIVU 100/7 completes behind it
    out_ready = 1'b0;
    op = 4'd0; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1;
    #1;
    check("hold_rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    op = 4'd12; operand_a = 32'd100; operand_b = 32'd7;
    #1;
    check("hold_rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (!(out_valid && out_data == 32'd3)) ok = 1'b0;
      @(negedge clk);
    end
    check("hold_stable", 64'(ok), 64'd1);
    check("hold_busy",   64'(busy), 64'd0);
    check("hold_rdy_lo", 64'(in_ready), 64'd0);
    check("hold_old",    64'(out_data), 64'd3);
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_new_vld", 64'(out_valid), 64'd1);
    check("hold_new_dat", 64'(out_data),  64'd14);
    @(negedge clk);
    check("hold_empty", 64'(out_valid), 64'd0);

    // Flush mid-DIV
    op = 4'd14; operand_a = 32'd1000; operand_b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_rdy",  64'(in_ready),  64'd1);
    check("flush_vld",  64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy),      64'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("flush_no_result", 64'(ok), 64'd1);

    // Reset pulse mid-MUL
    op = 4'd11; operand_a = 32'd5; operand_b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_vld",  64'(out_valid), 64'd0);
    check("mrst_dat",  64'(out_data),  64'd0);
    check("mrst_busy", 64'(busy),      64'd0);
    check("mrst_rdy",  64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("mrst_no_result", 64'(ok), 64'd1);

    // Randomized traffic with random backpressure
    prev_hold = 1'b0;
    prev_dat  = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        check("stable_vld", 64'(out_valid), 64'd1);
        check("stable_dat", 64'(out_data),  64'(prev_dat));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 4'($urandom_range(0, 15));
      operand_a = pick();
      operand_b = pick();
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) exp_v = {31'd0, 1'b1, exp_q.pop_front()};
        else                   exp_v = '0;
        check("rand_res", {31'd0, 1'b1, out_data}, exp_v);
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, operand_a, operand_b));
      prev_hold = out_valid && !out_ready;
      prev_dat  = out_data;
    end

    // Drain remaining results
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        exp_v = {31'd0, 1'b1, exp_q.pop_front()};
        check("drain_res", {31'd0, 1'b1, out_data}, exp_v);
      end
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
